// File: rtl/pulse_cfg_sequencer.sv
// pulse_cfg_sequencer
// Buffers host pulse-width commands in a small FIFO and applies them one at a
// time to a bank of pulse extenders over a set/value/ack handshake. A shadow
// copy of every channel's programmed width is kept for readback.
// Optional build macro PULSE_CFG_TIMEOUT_EN adds a WAIT-state ack timeout with
// a sticky error flag. Without it, WAIT waits indefinitely and out_error is 0.
module pulse_cfg_sequencer #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    input  logic                        in_cmd_valid,
    input  logic [$clog2(CHANNELS)-1:0] in_cmd_channel,
    input  logic [WIDTH-1:0]            in_cmd_value,
    output logic                        out_cmd_ready,
    output logic [CHANNELS-1:0]         out_set,
    output logic [WIDTH-1:0]            out_value,
    input  logic [CHANNELS-1:0]         in_ack,
    output logic                        out_busy,
    output logic                        out_done,
    output logic                        out_error,
    input  logic [$clog2(CHANNELS)-1:0] in_rb_channel,
    output logic [WIDTH-1:0]            out_rb_value
);
    localparam int CH_W = $clog2(CHANNELS);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    // A zero width would give no pulse at all, so the smallest legal width is used.
    function automatic logic [WIDTH-1:0] clamp_width(input logic [WIDTH-1:0] v);
        return (v == '0) ? WIDTH'(1) : v;
    endfunction

    function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
        return 32'(ch) < 32'(CHANNELS);
    endfunction

    function automatic logic [CHANNELS-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [CHANNELS-1:0] m;
        m = '0;
        for (int i = 0; i < CHANNELS; i++) m[i] = (ch == CH_W'(i));
        return m;
    endfunction

    logic [CH_W-1:0]     fifo_ch  [FIFO_DEPTH];
    logic [WIDTH-1:0]    fifo_val [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push_wr, pop;
    logic [CH_W-1:0]     head_ch;
    logic [WIDTH-1:0]    head_val;
    state_t              state, state_nxt;
    logic [CHANNELS-1:0] act_mask;
    logic                ack_hit, timeout_hit, shadow_we;
    logic [WIDTH-1:0]    shadow [CHANNELS];

    // Ready depends only on fullness, so a same-cycle pop never reopens a full FIFO.
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_cmd_ready = !fifo_full;
    // Out-of-range channels are handshaken but never stored.
    assign push_wr       = in_cmd_valid && !fifo_full && ch_in_range(in_cmd_channel);
    assign head_ch       = fifo_ch[rd_ptr[AW-1:0]];
    assign head_val      = fifo_val[rd_ptr[AW-1:0]];
    assign ack_hit       = |(in_ack & act_mask);

    // FIFO pointer update
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage write, value clamped on the way in
    always_ff @(posedge in_clock) begin
        if (push_wr) begin
            fifo_ch[wr_ptr[AW-1:0]]  <= in_cmd_channel;
            fifo_val[wr_ptr[AW-1:0]] <= clamp_width(in_cmd_value);
        end
    end

    // FSM state register
    always_ff @(posedge in_clock) begin
        if (in_reset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (ack_hit || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM decoded controls
    always_comb begin
        pop       = (state == S_IDLE) && !fifo_empty;
        shadow_we = (state == S_WAIT) && ack_hit;
        out_busy  = !fifo_empty || (state != S_IDLE);
    end

    // Registered handshake outputs; set lasts exactly the ISSUE cycle
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            out_set   <= '0;
            out_value <= '0;
            out_done  <= 1'b0;
        end else begin
            out_set  <= pop ? ch_onehot(head_ch) : '0;
            out_done <= shadow_we;
            if (pop) out_value <= head_val;
        end
    end

    // Channel being served, used to filter acks from the other extenders
    always_ff @(posedge in_clock) begin
        if (pop) act_mask <= ch_onehot(head_ch);
    end

    // Shadow widths start at 1 to match the extender reset width
    always_ff @(posedge in_clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_reset)                         shadow[i] <= WIDTH'(1);
            else if (shadow_we && act_mask[i])    shadow[i] <= out_value;
        end
    end

    // Readback mux, zero for indices without a channel
    always_comb begin
        out_rb_value = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_rb_channel == CH_W'(i)) out_rb_value = shadow[i];
        end
    end

`ifdef PULSE_CFG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;

    // Fires on the TIMEOUT-th WAIT cycle without an ack
    assign timeout_hit = (state == S_WAIT) && !ack_hit && (wait_cnt == TO_W'(TIMEOUT - 1));

    // WAIT cycle counter, cleared while in ISSUE so it starts at 0 in WAIT
    always_ff @(posedge in_clock) begin
        if (state == S_ISSUE)     wait_cnt <= '0;
        else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky timeout flag
    always_ff @(posedge in_clock) begin
        if (in_reset)         out_error <= 1'b0;
        else if (timeout_hit) out_error <= 1'b1;
    end
`else
    // TIMEOUT only matters when the ack timeout is built.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign out_error      = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_cfg_sequencer.sv
// Directed bench for pulse_cfg_sequencer: a 4-channel instance with a
// behavioural extender ack model, plus a 5-channel instance used to reach an
// out-of-range channel index.
module tb_pulse_cfg_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_ch;
    logic [7:0] cmd_val;
    logic       cmd_ready;
    logic [3:0] set;
    logic [7:0] value;
    logic [3:0] ack;
    logic       busy, done, error;
    logic [1:0] rb_ch;
    logic [7:0] rb_val;

    logic       cmd_valid2;
    logic [2:0] cmd_ch2;
    logic [7:0] cmd_val2;
    logic       cmd_ready2;
    logic [4:0] set2;
    logic [7:0] value2;
    logic [4:0] ack2;
    logic       busy2, done2, error2;
    logic [2:0] rb_ch2;
    logic [7:0] rb_val2;

    int checks = 0;
    int errors = 0;

    logic [3:0] model_ack;
    logic [3:0] manual_ack;
    logic [3:0] pend;
    bit         ack_en;
    int         ack_delay;
    int         ack_cnt;

    logic [3:0] set_log[$];
    logic [7:0] val_log[$];
    int         done_cnt = 0;
    int         viol = 0;
    logic [3:0] prev_set = '0;

    assign ack = model_ack | manual_ack;

    always #5 clk = ~clk;

    pulse_cfg_sequencer #(.CHANNELS(4), .WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT(15)) dut (
        .in_clock(clk), .in_reset(rst), .in_cmd_valid(cmd_valid), .in_cmd_channel(cmd_ch),
        .in_cmd_value(cmd_val), .out_cmd_ready(cmd_ready), .out_set(set), .out_value(value),
        .in_ack(ack), .out_busy(busy), .out_done(done), .out_error(error),
        .in_rb_channel(rb_ch), .out_rb_value(rb_val)
    );

    pulse_cfg_sequencer #(.CHANNELS(5), .WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT(15)) dut2 (
        .in_clock(clk), .in_reset(rst), .in_cmd_valid(cmd_valid2), .in_cmd_channel(cmd_ch2),
        .in_cmd_value(cmd_val2), .out_cmd_ready(cmd_ready2), .out_set(set2), .out_value(value2),
        .in_ack(ack2), .out_busy(busy2), .out_done(done2), .out_error(error2),
        .in_rb_channel(rb_ch2), .out_rb_value(rb_val2)
    );

    // Extender model: ack the set channel ack_delay cycles after set is seen.
    initial begin
        model_ack = '0;
        pend      = '0;
        ack_cnt   = 0;
        forever begin
            @(negedge clk);
            model_ack = '0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0 && ack_en) model_ack = pend;
            end
            if (set != '0) begin
                pend    = set;
                ack_cnt = ack_delay;
            end
        end
    end

    // Activity recorder for set strobes and done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (set != '0) begin
                set_log.push_back(set);
                val_log.push_back(value);
                if (prev_set != '0) viol++;
                if (!$onehot(set))  viol++;
            end
            prev_set = set;
            if (done) done_cnt++;
        end
    end

    task automatic push_cmd(input logic [1:0] ch, input logic [7:0] v);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_val   = v;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_rb2 [8];
        exp_rb2 = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (set !== 4'b0000) begin errors++; $display("FAIL reset_set: got %b expected 0000", set); end
        checks++; if (value !== 8'd0) begin errors++; $display("FAIL reset_value: got %0d expected 0", value); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_error: got %b%b expected 00", done, error); end
        for (int c = 0; c < 4; c++) begin
            rb_ch = 2'(c);
            #1;
            checks++; if (rb_val !== 8'd1) begin errors++; $display("FAIL reset_rb ch%0d: got %0d expected 1", c, rb_val); end
        end
        for (int c = 0; c < 8; c++) begin
            rb_ch2 = 3'(c);
            #1;
            checks++; if (rb_val2 !== exp_rb2[c]) begin errors++; $display("FAIL reset_rb2 ch%0d: got %0d expected %0d", c, rb_val2, exp_rb2[c]); end
        end
    endtask

    task automatic test_single();
        ack_en = 1'b1; ack_delay = 1; rb_ch = 2'd2;
        push_cmd(2'd2, 8'd40);
        checks++; if (set !== 4'b0000) begin errors++; $display("FAIL single_set_early: got %b expected 0000", set); end
        @(negedge clk);
        checks++; if (set !== 4'b0100) begin errors++; $display("FAIL single_set: got %b expected 0100", set); end
        checks++; if (value !== 8'd40) begin errors++; $display("FAIL single_value: got %0d expected 40", value); end
        @(negedge clk);
        checks++; if (set !== 4'b0000) begin errors++; $display("FAIL single_set_len: got %b expected 0000", set); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_wait: got done=%b busy=%b expected done=0 busy=1", done, busy); end
        checks++; if (rb_val !== 8'd1) begin errors++; $display("FAIL single_rb_before: got %0d expected 1", rb_val); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done); end
        checks++; if (rb_val !== 8'd40) begin errors++; $display("FAIL single_rb: got %0d expected 40", rb_val); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (value !== 8'd40) begin errors++; $display("FAIL single_value_hold: got %0d expected 40", value); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] chs  [6];
        logic [7:0] vals [6];
        logic [3:0] exp_set [5];
        logic [7:0] exp_rb [4];
        logic       acc [6];
        int d0, t;
        chs     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        vals    = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
        exp_set = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_rb  = '{8'd55, 8'd22, 8'd33, 8'd44};
        ack_en = 1'b1; ack_delay = 10;
        set_log.delete(); val_log.delete();
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_ch = chs[i]; cmd_val = vals[i];
            acc[i] = cmd_ready;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (acc[i] !== (i < 5)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, acc[i], (i < 5)); end
        end
        t = 0;
        while ((busy || (done_cnt - d0) < 5) && t < 300) begin @(negedge clk); t++; end
        checks++; if (t >= 300) begin errors++; $display("FAIL b2b_timeout: got %0d cycles expected < 300", t); end
        checks++; if (set_log.size() != 5) begin errors++; $display("FAIL b2b_set_count: got %0d expected 5", set_log.size()); end
        for (int i = 0; i < 5 && i < set_log.size(); i++) begin
            checks++;
            if (set_log[i] !== exp_set[i] || val_log[i] !== vals[i]) begin
                errors++; $display("FAIL b2b_order[%0d]: got %b/%0d expected %b/%0d", i, set_log[i], val_log[i], exp_set[i], vals[i]);
            end
        end
        checks++; if ((done_cnt - d0) != 5) begin errors++; $display("FAIL b2b_done_count: got %0d expected 5", done_cnt - d0); end
        checks++; if (viol != 0) begin errors++; $display("FAIL set_shape: got %0d violations expected 0", viol); end
        for (int c = 0; c < 4; c++) begin
            rb_ch = 2'(c);
            #1;
            checks++; if (rb_val !== exp_rb[c]) begin errors++; $display("FAIL b2b_rb ch%0d: got %0d expected %0d", c, rb_val, exp_rb[c]); end
        end
    endtask

    task automatic test_clamp();
        ack_en = 1'b1; ack_delay = 1; rb_ch = 2'd1;
        set_log.delete(); val_log.delete();
        push_cmd(2'd1, 8'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (set_log.size() != 1 || val_log[0] !== 8'd1) begin
            errors++; $display("FAIL clamp_value: got %0d entries, first value %0d expected 1 entry value 1", set_log.size(), (set_log.size() > 0) ? val_log[0] : 8'd0);
        end
        checks++; if (rb_val !== 8'd1) begin errors++; $display("FAIL clamp_rb: got %0d expected 1", rb_val); end
    endtask

    task automatic test_out_of_range();
        logic r;
        int n_set, n_done, n_busy;
        n_set = 0; n_done = 0; n_busy = 0;
        @(negedge clk);
        cmd_valid2 = 1'b1; cmd_ch2 = 3'd5; cmd_val2 = 8'd9;
        r = cmd_ready2;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b expected 1", r); end
        repeat (5) begin
            if (set2 != '0) n_set++;
            if (done2)      n_done++;
            if (busy2)      n_busy++;
            @(negedge clk);
        end
        checks++; if (n_set != 0 || n_done != 0 || n_busy != 0) begin errors++; $display("FAIL oor_discard: got set=%0d done=%0d busy=%0d expected 0 0 0", n_set, n_done, n_busy); end
        cmd_valid2 = 1'b1; cmd_ch2 = 3'd4; cmd_val2 = 8'd7;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        @(negedge clk);
        checks++; if (set2 !== 5'b10000 || value2 !== 8'd7) begin errors++; $display("FAIL oor_ch4_set: got %b/%0d expected 10000/7", set2, value2); end
        @(negedge clk);
        ack2 = 5'b10000;
        @(negedge clk);
        ack2 = '0;
        rb_ch2 = 3'd4;
        #1;
        checks++; if (done2 !== 1'b1 || rb_val2 !== 8'd7) begin errors++; $display("FAIL oor_ch4_done: got done=%b rb=%0d expected 1 7", done2, rb_val2); end
        rb_ch2 = 3'd5;
        #1;
        checks++; if (rb_val2 !== 8'd0) begin errors++; $display("FAIL oor_rb5: got %0d expected 0", rb_val2); end
    endtask

`ifdef PULSE_CFG_TIMEOUT_EN
    task automatic test_ack_withheld();
        ack_en = 1'b0; ack_delay = 1;
        push_cmd(2'd0, 8'd3);
        push_cmd(2'd1, 8'd50);
        repeat (14) @(negedge clk);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: got err=%b busy=%b expected 0 1", error, busy); end
        @(negedge clk);
        checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL to_fire: got err=%b done=%b expected 1 0", error, done); end
        ack_en = 1'b1;
        @(negedge clk);
        checks++; if (set !== 4'b0010) begin errors++; $display("FAIL to_next_set: got %b expected 0010", set); end
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL to_next_done: got done=%b err=%b expected 1 1", done, error); end
        rb_ch = 2'd0;
        #1;
        checks++; if (rb_val !== 8'd55) begin errors++; $display("FAIL to_shadow: got %0d expected 55", rb_val); end
        rb_ch = 2'd1;
        #1;
        checks++; if (rb_val !== 8'd50) begin errors++; $display("FAIL to_next_rb: got %0d expected 50", rb_val); end
    endtask
`else
    task automatic test_ack_withheld();
        ack_en = 1'b0; ack_delay = 1; rb_ch = 2'd0;
        push_cmd(2'd0, 8'd3);
        repeat (30) @(negedge clk);
        checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL hold_wait: got busy=%b err=%b expected 1 0", busy, error); end
        checks++; if (rb_val !== 8'd55) begin errors++; $display("FAIL hold_shadow: got %0d expected 55", rb_val); end
        manual_ack = 4'b0010;
        @(negedge clk);
        manual_ack = '0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL other_ack: got done=%b busy=%b expected 0 1", done, busy); end
        manual_ack = 4'b0001;
        @(negedge clk);
        manual_ack = '0;
        checks++; if (done !== 1'b1 || rb_val !== 8'd3) begin errors++; $display("FAIL late_own_ack: got done=%b rb=%0d expected 1 3", done, rb_val); end
        ack_en = 1'b1;
    endtask
`endif

    task automatic test_reset_in_wait();
        int n_done;
        ack_en = 1'b1; ack_delay = 5;
        push_cmd(2'd3, 8'd77);
        push_cmd(2'd2, 8'd88);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (set !== 4'b0000 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_wait: got set=%b busy=%b ready=%b expected 0000 0 1", set, busy, cmd_ready); end
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++; if (n_done != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got done=%0d busy=%b expected 0 0", n_done, busy); end
        rb_ch = 2'd3;
        #1;
        checks++; if (rb_val !== 8'd1) begin errors++; $display("FAIL rst_shadow3: got %0d expected 1", rb_val); end
        rb_ch = 2'd2;
        #1;
        checks++; if (rb_val !== 8'd1) begin errors++; $display("FAIL rst_shadow2: got %0d expected 1", rb_val); end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_ch = '0; cmd_val = '0; rb_ch = '0;
        cmd_valid2 = 1'b0; cmd_ch2 = '0; cmd_val2 = '0; rb_ch2 = '0; ack2 = '0;
        manual_ack = '0; ack_en = 1'b1; ack_delay = 1;
        test_reset();
        test_single();
        test_back_to_back();
        test_clamp();
        test_out_of_range();
        test_ack_withheld();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
